fft_stream_adapter: RTL
=======================

FFT_STREAM_ADAPTER -- requirements
Module: fft_stream_adapter

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each real or imaginary sample.
REQ-002 Parameter Num_of_samples, default 256: FFT frame length N; a power of LANES, and at least LANES*LANES.
REQ-003 Parameter LANES, default 4: core lanes per beat; N/LANES beats form one frame.
REQ-004 Port clock, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port s_valid / s_ready, input / output, 1 each: upstream serial-sample handshake.
REQ-007 Port s_real, input, WIDTH: upstream real sample.
REQ-008 Port s_imag, input, WIDTH: upstream imaginary sample; present only when COMPLEX_IN_EN is defined.
REQ-009 Port core_input_en, output, 1: beat strobe to the FFT core.
REQ-010 Port core_in_real / core_in_imag, output, LANES*WIDTH each: packed lane data to the core; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 Port core_output_en, input, 1: result beat strobe from the FFT core.
REQ-012 Port core_out_real / core_out_imag, input, LANES*WIDTH each: packed lane results from the core.
REQ-013 Port m_valid / m_ready, output / input, 1 each: downstream serial handshake.
REQ-014 Port m_real / m_imag, output, WIDTH each: downstream result sample.
REQ-015 Port m_last, output, 1: high on the final sample of each frame.
REQ-016 Port overflow, output, 1: sticky error flag.

Function
REQ-017 Input FSM states: FILL, LAUNCH, WAIT.
REQ-018 FILL: s_ready=1; each accepted sample (s_valid&&s_ready) is written to input buffer index in_cnt; in_cnt then increments.
REQ-019 Acceptance of sample N-1 moves the FSM to LAUNCH on the next cycle and clears in_cnt.
REQ-020 LAUNCH: s_ready=0; core_input_en is held high for exactly N/LANES consecutive cycles.
REQ-021 On launch beat b, lane k carries buffer sample b*LANES+k.
REQ-022 The first launch beat occurs the cycle after the last sample is accepted.
REQ-023 After the final launch beat, the input FSM moves to WAIT.
REQ-024 WAIT: s_ready=0; the FSM returns to FILL on the cycle after the output side finishes draining the frame (m_last accepted). At most one frame is ever in flight.
REQ-025 Output FSM states: IDLE, CAPTURE, DRAIN.
REQ-026 core_output_en high in IDLE or CAPTURE writes all LANES lanes into the output buffer at beat index out_beat; out_beat then increments.
REQ-027 Capture of beat N/LANES-1 moves the output FSM to DRAIN.
REQ-028 DRAIN: m_valid=1; output sample j is drawn from beat j/LANES, lane j%LANES, in order j=0..N-1.
REQ-029 The drain index advances only on m_valid&&m_ready; m_real, m_imag and m_last hold stable while m_ready=0.
REQ-030 m_last=1 only when j=N-1; acceptance of that sample returns the output FSM to IDLE.
REQ-031 Any core_output_en during DRAIN sets overflow; the beat is discarded and no buffer entry changes.
REQ-032 overflow clears only on reset.
REQ-033 Data passes through unmodified: no scaling, no rounding, no sign change.
REQ-034 Sample counters wrap only at frame boundaries.
REQ-035 Simultaneous s_valid and m_ready in the same cycle are legal and independent.

Reset
REQ-036 Reset asserted immediately sets: s_ready=0, core_input_en=0, core_in_real=0, core_in_imag=0, m_valid=0, m_last=0, m_real=0, m_imag=0, overflow=0.
REQ-037 On the first clock edge after reset deasserts: input FSM in FILL with s_ready=1, output FSM in IDLE, all counters 0.
REQ-038 Reset mid-frame discards all partial input and output data; buffer contents need not be cleared.

Configuration
REQ-039 Macro COMPLEX_IN_EN defined: s_imag exists, is buffered with s_real, and drives core_in_imag lanes.
REQ-040 Macro COMPLEX_IN_EN undefined: s_imag is absent and core_in_imag is constant 0; all other behaviour is identical.

Verification
REQ-041 N=16, LANES=4; push samples 1..16 back-to-back -> core_input_en high 4 cycles starting the cycle after sample 16 is accepted; beat 0 lanes = 1,2,3,4; beat 3 lanes = 13,14,15,16.
REQ-042 Drive 4 core beats with real = 100+j, m_ready=1 -> m_valid rises the cycle after capture; outputs 100..115 on consecutive cycles; m_last only on 115.
REQ-043 Hold m_ready=0 for 5 cycles mid-drain -> m_real holds its value; no sample is lost or duplicated; s_ready stays 0 until m_last is accepted.
REQ-044 Pulse core_output_en during DRAIN -> overflow=1 and stays 1; drained data unchanged.
REQ-045 Assert reset after 7 of 16 samples are accepted -> all outputs immediately 0; after release a full new frame launches with fresh data only.
REQ-046 COMPLEX_IN_EN defined, s_imag = -s_real -> each core_in_imag lane equals the negation of its core_in_real lane; undefined -> core_in_imag=0.

Source files
------------

// File: rtl/fft_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : fft_stream_adapter
// Purpose  : Bridges a serial sample stream to a multi-lane FFT core and back.
//            A full frame of Num_of_samples serial samples is buffered. It is
//            launched to the core as Num_of_samples/LANES parallel beats. The
//            returned core beats are captured and drained back out serially.
//            Only one frame is ever in flight: the next frame is not accepted
//            until the previous one has fully drained downstream.
// Ports    : clock, reset        - rising-edge clock, async active-high reset
//            s_valid/s_ready     - upstream serial handshake
//            s_real[, s_imag]    - upstream sample (s_imag only with macro)
//            core_input_en       - launch beat strobe to the core
//            core_in_real/imag   - packed launch lanes, lane k at [k*WIDTH +: WIDTH]
//            core_output_en      - result beat strobe from the core
//            core_out_real/imag  - packed result lanes
//            m_valid/m_ready     - downstream serial handshake
//            m_real, m_imag      - downstream sample
//            m_last              - final sample of each frame
//            overflow            - sticky: core beat arrived while draining
// Macro    : COMPLEX_IN_EN - adds s_imag and buffers it into core_in_imag;
//            when undefined core_in_imag is constant zero.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stream_adapter #(
  parameter int WIDTH          = 16,
  parameter int Num_of_samples = 256,
  parameter int LANES          = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_real,
`ifdef COMPLEX_IN_EN
  input  logic [WIDTH-1:0]       s_imag,
`endif
  output logic                   core_input_en,
  output logic [LANES*WIDTH-1:0] core_in_real,
  output logic [LANES*WIDTH-1:0] core_in_imag,
  input  logic                   core_output_en,
  input  logic [LANES*WIDTH-1:0] core_out_real,
  input  logic [LANES*WIDTH-1:0] core_out_imag,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_real,
  output logic [WIDTH-1:0]       m_imag,
  output logic                   m_last,
  output logic                   overflow
);

  localparam int c_BEATS  = Num_of_samples / LANES;
  localparam int c_IDX_W  = $clog2(Num_of_samples);
  localparam int c_BEAT_W = $clog2(c_BEATS);

  localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(Num_of_samples - 1);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
  localparam logic [c_IDX_W-1:0]  c_LANES_IDX = c_IDX_W'(LANES);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } out_state_t;

  // --------------------------------------------------------------------------
  // Frame buffers (contents are not reset; counters define what is valid)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_in_real  [Num_of_samples];
`ifdef COMPLEX_IN_EN
  logic [WIDTH-1:0] r_in_imag  [Num_of_samples];
`endif
  logic [WIDTH-1:0] r_out_real [Num_of_samples];
  logic [WIDTH-1:0] r_out_imag [Num_of_samples];

  in_state_t           r_in_state,  w_in_state_nxt;
  logic [c_IDX_W-1:0]  r_in_cnt,    w_in_cnt_nxt;
  logic [c_BEAT_W-1:0] r_launch_beat, w_launch_beat_nxt;

  out_state_t          r_out_state, w_out_state_nxt;
  logic [c_BEAT_W-1:0] r_out_beat,  w_out_beat_nxt;
  logic [c_IDX_W-1:0]  r_drain_idx, w_drain_idx_nxt;

  logic r_overflow;

  logic               w_s_accept;
  logic               w_frame_done;
  logic               w_capture;
  logic [c_IDX_W-1:0] w_in_base;
  logic [c_IDX_W-1:0] w_out_base;

  // s_ready is masked by reset so it reads 0 while reset is held even though
  // the input FSM already sits in FILL.
  assign s_ready      = (r_in_state == FILL) && !reset;
  assign w_s_accept   = s_valid && s_ready;
  assign w_frame_done = m_valid && m_ready && m_last;
  // Beats arriving during DRAIN are discarded; they only raise overflow.
  assign w_capture    = core_output_en && (r_out_state != DRAIN);
  assign w_in_base    = c_IDX_W'(r_launch_beat) * c_LANES_IDX;
  assign w_out_base   = c_IDX_W'(r_out_beat) * c_LANES_IDX;
  assign overflow     = r_overflow;

  // --------------------------------------------------------------------------
  // Input FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_state    <= FILL;
      r_in_cnt      <= '0;
      r_launch_beat <= '0;
    end else begin
      r_in_state    <= w_in_state_nxt;
      r_in_cnt      <= w_in_cnt_nxt;
      r_launch_beat <= w_launch_beat_nxt;
    end
  end

  always_comb begin
    w_in_state_nxt    = r_in_state;
    w_in_cnt_nxt      = r_in_cnt;
    w_launch_beat_nxt = r_launch_beat;
    case (r_in_state)
      FILL: begin
        if (w_s_accept) begin
          if (r_in_cnt == c_LAST_IDX) begin
            w_in_cnt_nxt      = '0;
            w_launch_beat_nxt = '0;
            w_in_state_nxt    = LAUNCH;
          end else begin
            w_in_cnt_nxt = r_in_cnt + 1'b1;
          end
        end
      end
      LAUNCH: begin
        if (r_launch_beat == c_LAST_BEAT) begin
          w_launch_beat_nxt = '0;
          w_in_state_nxt    = WAIT;
        end else begin
          w_launch_beat_nxt = r_launch_beat + 1'b1;
        end
      end
      WAIT: begin
        if (w_frame_done) begin
          w_in_state_nxt = FILL;
        end
      end
      default: begin
        w_in_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_s_accept) begin
      r_in_real[r_in_cnt] <= s_real;
`ifdef COMPLEX_IN_EN
      r_in_imag[r_in_cnt] <= s_imag;
`endif
    end
  end

  // Launch lanes are only driven during LAUNCH so the core sees zeros otherwise.
  always_comb begin
    core_input_en = (r_in_state == LAUNCH);
    core_in_real  = '0;
    if (r_in_state == LAUNCH) begin
      for (int k = 0; k < LANES; k++) begin
        core_in_real[k*WIDTH +: WIDTH] = r_in_real[w_in_base + c_IDX_W'(k)];
      end
    end
  end

`ifdef COMPLEX_IN_EN
  always_comb begin
    core_in_imag = '0;
    if (r_in_state == LAUNCH) begin
      for (int k = 0; k < LANES; k++) begin
        core_in_imag[k*WIDTH +: WIDTH] = r_in_imag[w_in_base + c_IDX_W'(k)];
      end
    end
  end
`else
  assign core_in_imag = '0;
`endif

  // --------------------------------------------------------------------------
  // Output FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_state <= IDLE;
      r_out_beat  <= '0;
      r_drain_idx <= '0;
    end else begin
      r_out_state <= w_out_state_nxt;
      r_out_beat  <= w_out_beat_nxt;
      r_drain_idx <= w_drain_idx_nxt;
    end
  end

  always_comb begin
    w_out_state_nxt = r_out_state;
    w_out_beat_nxt  = r_out_beat;
    w_drain_idx_nxt = r_drain_idx;
    case (r_out_state)
      IDLE, CAPTURE: begin
        if (core_output_en) begin
          if (r_out_beat == c_LAST_BEAT) begin
            w_out_beat_nxt  = '0;
            w_drain_idx_nxt = '0;
            w_out_state_nxt = DRAIN;
          end else begin
            w_out_beat_nxt  = r_out_beat + 1'b1;
            w_out_state_nxt = CAPTURE;
          end
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (r_drain_idx == c_LAST_IDX) begin
            w_drain_idx_nxt = '0;
            w_out_state_nxt = IDLE;
          end else begin
            w_drain_idx_nxt = r_drain_idx + 1'b1;
          end
        end
      end
      default: begin
        w_out_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_capture) begin
      for (int k = 0; k < LANES; k++) begin
        r_out_real[w_out_base + c_IDX_W'(k)] <= core_out_real[k*WIDTH +: WIDTH];
        r_out_imag[w_out_base + c_IDX_W'(k)] <= core_out_imag[k*WIDTH +: WIDTH];
      end
    end
  end

  // The flat buffer index equals beat*LANES + lane, so the drain index selects
  // beat j/LANES, lane j%LANES directly.
  always_comb begin
    m_valid = (r_out_state == DRAIN);
    m_last  = 1'b0;
    m_real  = '0;
    m_imag  = '0;
    if (r_out_state == DRAIN) begin
      m_last = (r_drain_idx == c_LAST_IDX);
      m_real = r_out_real[r_drain_idx];
      m_imag = r_out_imag[r_drain_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (core_output_en && (r_out_state == DRAIN)) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
